// File: rtl/spiking_neuron_param_if.sv
// Configuration bus, synapse inputs and observation outputs of one neuron.
// master: addr_i, cmd_i, cmd_arg_i, in_i -> neuron; slave: out_o, potential_o, spike_count_o.
interface spiking_neuron_param_if #(
    parameter int FLOAT_WIDTH = 16,
    parameter int CMD_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_INPUTS  = 4,
    parameter int ACC_WIDTH   = FLOAT_WIDTH + 4
);
    logic        [ADDR_WIDTH-1:0]  addr_i;
    logic        [CMD_WIDTH-1:0]   cmd_i;
    logic signed [FLOAT_WIDTH-1:0] cmd_arg_i;
    logic        [NUM_INPUTS-1:0]  in_i;
    logic                          out_o;
    logic signed [ACC_WIDTH-1:0]   potential_o;
    logic        [15:0]            spike_count_o;

    modport master (
        output addr_i, cmd_i, cmd_arg_i, in_i,
        input  out_o, potential_o, spike_count_o
    );

    modport slave (
        input  addr_i, cmd_i, cmd_arg_i, in_i,
        output out_o, potential_o, spike_count_o
    );
endinterface

// File: rtl/spiking_neuron_param.sv
// Parametrised leaky integrate-and-fire neuron with addressed config bus.
// Ports: clk, rst (async, active high), nrn (slave: addr/cmd/arg/in -> out/potential/spike_count).
module spiking_neuron_param #(
    parameter int INT_WIDTH   = 8,
    parameter int FLOAT_WIDTH = 2 * INT_WIDTH,
    parameter int CMD_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int NEURON_ADDR = 1,
    parameter int NUM_INPUTS  = 4,
    parameter int MAX_DELAY   = 15,
    parameter int ACC_WIDTH   = FLOAT_WIDTH + 4
) (
    input logic                   clk,
    input logic                   rst,
    spiking_neuron_param_if.slave nrn
);
    localparam int DT_W  = $clog2(MAX_DELAY + 1);
    // Headroom for V, its leak term, bias and every weight summed at once.
    localparam int SUM_W = ACC_WIDTH + $clog2(NUM_INPUTS + 2) + 2;

    localparam logic [CMD_WIDTH-1:0] CMD_NOP       = '0;
    localparam logic [CMD_WIDTH-1:0] CMD_SET_DT    = '1;
    localparam logic [CMD_WIDTH-1:0] CMD_SET_BIAS  = ~CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_CLEAR     = ~CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] CMD_SET_THR   = ~CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] CMD_SET_LEAK  = ~CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] CMD_SET_REFR  = ~CMD_WIDTH'(7);

    localparam logic signed [FLOAT_WIDTH-1:0] THR_RST =
        FLOAT_WIDTH'((2 ** INT_WIDTH) - 1);

    localparam logic signed [SUM_W-1:0] SAT_HI =
        {{(SUM_W - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_LO =
        {{(SUM_W - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};

    // Configuration registers
    logic signed [FLOAT_WIDTH-1:0] weight_q [NUM_INPUTS];
    logic signed [FLOAT_WIDTH-1:0] weight_d [NUM_INPUTS];
    logic signed [FLOAT_WIDTH-1:0] bias_q, bias_d;
    logic signed [FLOAT_WIDTH-1:0] thr_q, thr_d;
    logic        [3:0]             leak_q, leak_d;
    logic        [7:0]             refr_q, refr_d;
    logic        [DT_W-1:0]        dt_q, dt_d;

    // Dynamic state
    logic signed [ACC_WIDTH-1:0]   v_q, v_d;
    logic                          fire_q, fire_d;
    logic        [7:0]             rcnt_q, rcnt_d;
    logic        [15:0]            cnt_q, cnt_d;
    logic        [MAX_DELAY-1:0]   dly_q, dly_d;

    // Integration datapath
    logic signed [SUM_W-1:0]       v_ext;
    logic signed [SUM_W-1:0]       leak_term;
    logic signed [SUM_W-1:0]       syn_sum;
    logic signed [SUM_W-1:0]       v_full;
    logic signed [ACC_WIDTH-1:0]   v_sat;
    logic                          fire_cond;

    // Command decode
    logic                          sel;
    logic                          is_wt;
    logic        [DT_W-1:0]        dt_arg;

    // taps[0] is the undelayed fire flag, taps[k] is it delayed k cycles.
    logic        [MAX_DELAY:0]     taps;

    assign taps = {dly_q, fire_q};

    assign nrn.out_o         = taps[dt_q];
    assign nrn.potential_o   = v_q;
    assign nrn.spike_count_o = cnt_q;

    always_comb begin
        v_ext     = SUM_W'(v_q);
        leak_term = (leak_q != '0) ? (v_ext >>> leak_q) : '0;
        syn_sum   = SUM_W'(bias_q);
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (nrn.in_i[i]) begin
                syn_sum = syn_sum + SUM_W'(weight_q[i]);
            end
        end
        v_full = v_ext - leak_term + syn_sum;
        if (v_full > SAT_HI) begin
            v_sat = SAT_HI[ACC_WIDTH-1:0];
        end else if (v_full < SAT_LO) begin
            v_sat = SAT_LO[ACC_WIDTH-1:0];
        end else begin
            v_sat = v_full[ACC_WIDTH-1:0];
        end
        fire_cond = (v_sat >= ACC_WIDTH'(thr_q));
    end

    always_comb begin
        sel   = (nrn.addr_i == ADDR_WIDTH'(NEURON_ADDR));
        is_wt = (nrn.cmd_i != CMD_NOP) &&
                (nrn.cmd_i <= CMD_WIDTH'(NUM_INPUTS));
        if (nrn.cmd_arg_i[FLOAT_WIDTH-1]) begin
            dt_arg = '0;
        end else if ($unsigned(nrn.cmd_arg_i) > FLOAT_WIDTH'(MAX_DELAY)) begin
            dt_arg = DT_W'(MAX_DELAY);
        end else begin
            dt_arg = DT_W'(nrn.cmd_arg_i);
        end
    end

    always_comb begin
        weight_d = weight_q;
        bias_d   = bias_q;
        thr_d    = thr_q;
        leak_d   = leak_q;
        refr_d   = refr_q;
        dt_d     = dt_q;
        v_d      = v_q;
        fire_d   = 1'b0;
        rcnt_d   = rcnt_q;
        cnt_d    = cnt_q;
        dly_d    = taps[MAX_DELAY-1:0];

        if (rcnt_q != '0) begin
            rcnt_d = rcnt_q - 8'd1;
            v_d    = '0;
        end else if (fire_cond) begin
            v_d    = '0;
            fire_d = 1'b1;
            rcnt_d = refr_q;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            v_d = v_sat;
        end

        // Writes land after this edge, so integration above saw the old config.
        if (sel) begin
            unique case (1'b1)
                is_wt: begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        if (nrn.cmd_i == CMD_WIDTH'(i + 1)) begin
                            weight_d[i] = nrn.cmd_arg_i;
                        end
                    end
                end
                (nrn.cmd_i == CMD_SET_DT): begin
                    dt_d  = dt_arg;
                    dly_d = '0;
                end
                (nrn.cmd_i == CMD_SET_BIAS): bias_d = nrn.cmd_arg_i;
                (nrn.cmd_i == CMD_CLEAR): begin
                    // Overrides a fire decided on this same edge.
                    v_d    = '0;
                    rcnt_d = '0;
                    dly_d  = '0;
                    fire_d = 1'b0;
                    cnt_d  = '0;
                end
                (nrn.cmd_i == CMD_SET_THR):  thr_d  = nrn.cmd_arg_i;
                (nrn.cmd_i == CMD_SET_LEAK): leak_d = nrn.cmd_arg_i[3:0];
                (nrn.cmd_i == CMD_SET_REFR): refr_d = nrn.cmd_arg_i[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                weight_q[i] <= '0;
            end
            bias_q <= '0;
            thr_q  <= THR_RST;
            leak_q <= '0;
            refr_q <= '0;
            dt_q   <= '0;
            v_q    <= '0;
            fire_q <= 1'b0;
            rcnt_q <= '0;
            cnt_q  <= '0;
            dly_q  <= '0;
        end else begin
            weight_q <= weight_d;
            bias_q   <= bias_d;
            thr_q    <= thr_d;
            leak_q   <= leak_d;
            refr_q   <= refr_d;
            dt_q     <= dt_d;
            v_q      <= v_d;
            fire_q   <= fire_d;
            rcnt_q   <= rcnt_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
        end
    end
endmodule

// File: tb/tb_spiking_neuron_param.sv
// Directed bench for spiking_neuron_param: vector table plus
// hand-written delivery, refractory, leak, clear and reset sequences.
module tb_spiking_neuron_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spiking_neuron_param_if #(
        .FLOAT_WIDTH(16), .CMD_WIDTH(8), .ADDR_WIDTH(8),
        .NUM_INPUTS(4), .ACC_WIDTH(20)
    ) bus ();

    spiking_neuron_param #(
        .INT_WIDTH(8), .FLOAT_WIDTH(16), .CMD_WIDTH(8), .ADDR_WIDTH(8),
        .NEURON_ADDR(1), .NUM_INPUTS(4), .MAX_DELAY(15), .ACC_WIDTH(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .nrn(bus)
    );

    typedef struct {
        string      nm;
        logic [7:0] addr;
        logic [7:0] cmd;
        int         arg;
        logic [3:0] in;
        logic       out;
        int         pot;
        int         cnt;
    } vec_t;

    int dt_args [4] = '{0, 12, 100, -5};
    int dt_eff  [4] = '{0, 12, 15, 0};
    int leak_exp[8] = '{100, 150, 175, 188, 194, 197, 199, 200};

    task automatic chk(input string nm, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp_v);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] c,
                         input int arg, input logic [3:0] inp);
        bus.addr_i    = a;
        bus.cmd_i     = c;
        bus.cmd_arg_i = 16'(arg);
        bus.in_i      = inp;
    endtask

    // One-cycle config write to this neuron; returns on the next negedge.
    task automatic wr(input logic [7:0] c, input int arg);
        bus.addr_i    = 8'd1;
        bus.cmd_i     = c;
        bus.cmd_arg_i = 16'(arg);
        @(negedge clk);
        bus.addr_i    = 8'd0;
        bus.cmd_i     = 8'd0;
        bus.cmd_arg_i = '0;
    endtask

    task automatic do_reset();
        drive(8'd0, 8'd0, 0, 4'h0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[$];
        int   fires;
        int   pulses;
        int   bad;
        logic exp_o;

        drive(8'd0, 8'd0, 0, 4'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst_out", int'(bus.out_o), 0);
        chk("rst_pot", int'(bus.potential_o), 0);
        chk("rst_cnt", int'(bus.spike_count_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        fires = 0;
        for (int c = 0; c < 50; c++) begin
            bus.in_i = 4'($urandom_range(0, 15));
            @(negedge clk);
            fires += int'(bus.out_o);
            if (bus.potential_o != '0) fires++;
        end
        chk("zero_weights_idle", fires, 0);
        bus.in_i = 4'h0;

        tv.push_back('{"wr_w0",    8'd1, 8'd1,   121,    4'h0, 1'b0, 0, 0});
        tv.push_back('{"int1",     8'd0, 8'd0,   0,      4'h1, 1'b0, 121, 0});
        tv.push_back('{"int2",     8'd0, 8'd0,   0,      4'h1, 1'b0, 242, 0});
        tv.push_back('{"fire1",    8'd0, 8'd0,   0,      4'h1, 1'b1, 0, 1});
        tv.push_back('{"int4",     8'd0, 8'd0,   0,      4'h1, 1'b0, 121, 1});
        tv.push_back('{"int5",     8'd0, 8'd0,   0,      4'h1, 1'b0, 242, 1});
        tv.push_back('{"fire2",    8'd0, 8'd0,   0,      4'h1, 1'b1, 0, 2});
        tv.push_back('{"wr_addr2", 8'd2, 8'd1,   5,      4'h1, 1'b0, 121, 2});
        tv.push_back('{"addr2_ign",8'd0, 8'd0,   0,      4'h1, 1'b0, 242, 2});
        tv.push_back('{"fire3",    8'd0, 8'd0,   0,      4'h1, 1'b1, 0, 3});
        tv.push_back('{"clear1",   8'd1, 8'd253, 0,      4'h0, 1'b0, 0, 0});
        tv.push_back('{"w0_255",   8'd1, 8'd1,   255,    4'h0, 1'b0, 0, 0});
        tv.push_back('{"w1_m255",  8'd1, 8'd2,   -255,   4'h0, 1'b0, 0, 0});
        tv.push_back('{"inhib1",   8'd0, 8'd0,   0,      4'h3, 1'b0, 0, 0});
        tv.push_back('{"inhib2",   8'd0, 8'd0,   0,      4'h3, 1'b0, 0, 0});
        tv.push_back('{"excite1",  8'd0, 8'd0,   0,      4'h1, 1'b1, 0, 1});
        tv.push_back('{"excite2",  8'd0, 8'd0,   0,      4'h1, 1'b1, 0, 2});
        tv.push_back('{"neg_in1",  8'd0, 8'd0,   0,      4'h2, 1'b0, -255, 2});
        tv.push_back('{"cmd_m4",   8'd1, 8'd252, 500,    4'h0, 1'b0, -255, 2});
        tv.push_back('{"clear2",   8'd1, 8'd253, 0,      4'h0, 1'b0, 0, 0});
        tv.push_back('{"w0_min",   8'd1, 8'd1,   -32768, 4'h0, 1'b0, 0, 0});
        tv.push_back('{"w1_min",   8'd1, 8'd2,   -32768, 4'h0, 1'b0, 0, 0});
        tv.push_back('{"w2_min",   8'd1, 8'd3,   -32768, 4'h0, 1'b0, 0, 0});
        tv.push_back('{"w3_min",   8'd1, 8'd4,   -32768, 4'h0, 1'b0, 0, 0});
        tv.push_back('{"sum1",     8'd0, 8'd0,   0,      4'hF, 1'b0, -131072, 0});
        tv.push_back('{"sum2",     8'd0, 8'd0,   0,      4'hF, 1'b0, -262144, 0});
        tv.push_back('{"sum3",     8'd0, 8'd0,   0,      4'hF, 1'b0, -393216, 0});
        tv.push_back('{"sum4",     8'd0, 8'd0,   0,      4'hF, 1'b0, -524288, 0});
        tv.push_back('{"sat_hold", 8'd0, 8'd0,   0,      4'hF, 1'b0, -524288, 0});
        tv.push_back('{"clear3",   8'd1, 8'd253, 0,      4'h0, 1'b0, 0, 0});

        foreach (tv[k]) begin
            drive(tv[k].addr, tv[k].cmd, tv[k].arg, tv[k].in);
            @(negedge clk);
            chk({tv[k].nm, "_out"}, int'(bus.out_o), int'(tv[k].out));
            chk({tv[k].nm, "_pot"}, int'(bus.potential_o), tv[k].pot);
            chk({tv[k].nm, "_cnt"}, int'(bus.spike_count_o), tv[k].cnt);
        end
        drive(8'd0, 8'd0, 0, 4'h0);

        // Delivery delay, including clamping of large and negative args
        for (int t = 0; t < 4; t++) begin
            do_reset();
            wr(8'd1, 121);
            wr(8'd255, dt_args[t]);
            pulses = 0;
            bad    = 0;
            bus.in_i = 4'h1;
            for (int c = 1; c <= 80; c++) begin
                @(negedge clk);
                if (c == 60) bus.in_i = 4'h0;
                exp_o = ((c - dt_eff[t]) >= 3) && ((c - dt_eff[t]) <= 60) &&
                        (((c - dt_eff[t]) % 3) == 0);
                pulses += int'(bus.out_o);
                if (bus.out_o !== exp_o) bad++;
            end
            chk($sformatf("dly%0d_pulses", dt_args[t]), pulses, 20);
            chk($sformatf("dly%0d_timing", dt_args[t]), bad, 0);
            chk($sformatf("dly%0d_cnt", dt_args[t]),
                int'(bus.spike_count_o), 20);
        end

        // Refractory = 3: bias alone fires, then 3 dead cycles
        do_reset();
        wr(8'd248, 3);
        wr(8'd254, 255);
        pulses = 0;
        bad    = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            exp_o = ((c % 4) == 1);
            pulses += int'(bus.out_o);
            if (bus.out_o !== exp_o) bad++;
        end
        chk("refr3_pulses", pulses, 5);
        chk("refr3_timing", bad, 0);
        chk("refr3_cnt", int'(bus.spike_count_o), 5);

        wr(8'd248, 0);
        wr(8'd253, 0);
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            pulses += int'(bus.out_o);
        end
        chk("refr0_pulses", pulses, 10);
        chk("refr0_cnt", int'(bus.spike_count_o), 10);

        // Leak shift 1 with bias 100 settles at 200, below threshold
        do_reset();
        wr(8'd249, 1);
        wr(8'd254, 100);
        fires = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c < 8) chk($sformatf("leak_pot%0d", c),
                           int'(bus.potential_o), leak_exp[c]);
            fires += int'(bus.out_o);
        end
        chk("leak_nofire", fires, 0);
        chk("leak_settle", int'(bus.potential_o), 200);

        wr(8'd250, 150);
        wr(8'd253, 0);
        @(negedge clk);
        chk("thr150_c1_pot", int'(bus.potential_o), 100);
        chk("thr150_c1_out", int'(bus.out_o), 0);
        @(negedge clk);
        chk("thr150_c2_out", int'(bus.out_o), 1);
        chk("thr150_c2_pot", int'(bus.potential_o), 0);
        chk("thr150_c2_cnt", int'(bus.spike_count_o), 1);

        // Clear while a spike sits in the delay line
        do_reset();
        wr(8'd1, 121);
        wr(8'd255, 12);
        bus.in_i = 4'h1;
        repeat (3) @(negedge clk);
        chk("race_cnt_pre", int'(bus.spike_count_o), 1);
        bus.in_i = 4'h0;
        repeat (4) @(negedge clk);
        wr(8'd253, 0);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            pulses += int'(bus.out_o);
        end
        chk("race_pulses", pulses, 0);
        chk("race_cnt", int'(bus.spike_count_o), 0);

        // Clear on the same edge as a fire condition
        do_reset();
        wr(8'd1, 121);
        bus.in_i = 4'h1;
        repeat (2) @(negedge clk);
        bus.addr_i = 8'd1;
        bus.cmd_i  = 8'd253;
        @(negedge clk);
        bus.addr_i = 8'd0;
        bus.cmd_i  = 8'd0;
        chk("cfire_out", int'(bus.out_o), 0);
        chk("cfire_pot", int'(bus.potential_o), 0);
        chk("cfire_cnt", int'(bus.spike_count_o), 0);
        repeat (3) @(negedge clk);
        chk("cfire_next_out", int'(bus.out_o), 1);
        chk("cfire_next_cnt", int'(bus.spike_count_o), 1);

        // Asynchronous reset drops a live output pulse
        do_reset();
        wr(8'd1, 121);
        bus.in_i = 4'h1;
        repeat (3) @(negedge clk);
        chk("arst_pre_out", int'(bus.out_o), 1);
        rst = 1'b1;
        #1;
        chk("arst_out", int'(bus.out_o), 0);
        chk("arst_cnt", int'(bus.spike_count_o), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_i = 4'h0;

        // Reset inside the delay window discards the queued spike
        do_reset();
        wr(8'd1, 121);
        wr(8'd255, 12);
        bus.in_i = 4'h1;
        repeat (3) @(negedge clk);
        bus.in_i = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            pulses += int'(bus.out_o);
        end
        chk("rstdly_pulses", pulses, 0);
        chk("rstdly_cnt", int'(bus.spike_count_o), 0);
        chk("rstdly_pot", int'(bus.potential_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
